// File: rtl/dtcm_arb_if.sv
// Two command/response ports plus the single-port RAM side of the DTCM arbiter.
// slave = arbiter side, master = requesters/RAM/testbench side.
interface dtcm_arb_if #(
  parameter int DW     = 32,
  parameter int ADDR_W = 16
);
  localparam int MW     = DW / 8;
  localparam int OFS    = $clog2(MW);
  localparam int RAM_AW = ADDR_W - OFS;

  logic              p0_cmd_valid, p0_cmd_ready, p0_cmd_read;
  logic [ADDR_W-1:0] p0_cmd_addr;
  logic [MW-1:0]     p0_cmd_wmask;
  logic [DW-1:0]     p0_cmd_wdata;
  logic              p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
  logic [DW-1:0]     p0_rsp_rdata;

  logic              p1_cmd_valid, p1_cmd_ready, p1_cmd_read;
  logic [ADDR_W-1:0] p1_cmd_addr;
  logic [MW-1:0]     p1_cmd_wmask;
  logic [DW-1:0]     p1_cmd_wdata;
  logic              p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
  logic [DW-1:0]     p1_rsp_rdata;

  logic              ram_cs, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [MW-1:0]     ram_wem;
  logic [DW-1:0]     ram_din, ram_dout;
  logic              busy;

  modport slave (
    input  p0_cmd_valid, p0_cmd_read, p0_cmd_addr, p0_cmd_wmask, p0_cmd_wdata, p0_rsp_ready,
    output p0_cmd_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
    input  p1_cmd_valid, p1_cmd_read, p1_cmd_addr, p1_cmd_wmask, p1_cmd_wdata, p1_rsp_ready,
    output p1_cmd_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
    output ram_cs, ram_we, ram_addr, ram_wem, ram_din, busy,
    input  ram_dout
  );

  modport master (
    output p0_cmd_valid, p0_cmd_read, p0_cmd_addr, p0_cmd_wmask, p0_cmd_wdata, p0_rsp_ready,
    input  p0_cmd_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
    output p1_cmd_valid, p1_cmd_read, p1_cmd_addr, p1_cmd_wmask, p1_cmd_wdata, p1_rsp_ready,
    input  p1_cmd_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
    input  ram_cs, ram_we, ram_addr, ram_wem, ram_din, busy,
    output ram_dout
  );
endinterface

// File: rtl/dtcm_arb_ctrl.sv
// Two-port round-robin arbiter in front of a single-port DTCM RAM, with credit-limited
// outstanding commands and an in-order shared response FIFO.
module dtcm_arb_ctrl #(
  parameter int DW        = 32,
  parameter int ADDR_W    = 16,
  parameter int RAM_LAT   = 1,
  parameter int RSP_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  dtcm_arb_if.slave     bus
);
  localparam int MW  = DW / 8;
  localparam int OFS = $clog2(MW);
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic port;
    logic read;
    logic err;
  } tag_t;

  typedef struct packed {
    logic          port;
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  logic [1:0]             w_cv, w_crd, w_gnt, w_rdy, w_rv, w_rr_in;
  logic [1:0][ADDR_W-1:0] w_addr;
  logic [1:0][MW-1:0]     w_wm;
  logic [1:0][DW-1:0]     w_wd;

  assign w_cv    = {bus.p1_cmd_valid, bus.p0_cmd_valid};
  assign w_crd   = {bus.p1_cmd_read,  bus.p0_cmd_read};
  assign w_addr  = {bus.p1_cmd_addr,  bus.p0_cmd_addr};
  assign w_wm    = {bus.p1_cmd_wmask, bus.p0_cmd_wmask};
  assign w_wd    = {bus.p1_cmd_wdata, bus.p0_cmd_wdata};
  assign w_rr_in = {bus.p1_rsp_ready, bus.p0_rsp_ready};

  logic          r_rr;
  logic [CW-1:0] r_outst;
  logic          w_credit, w_acc, w_sel, w_mis, w_cs, w_we;

  // Ready is masked by rst so nothing is accepted while reset is held.
  assign w_credit = r_outst < CW'(RSP_DEPTH);
  assign w_gnt[0] = w_cv[0] & (~w_cv[1] | ~r_rr);
  assign w_gnt[1] = w_cv[1] & (~w_cv[0] | r_rr);
  assign w_rdy    = w_gnt & {2{w_credit & ~rst}};
  assign w_acc    = |w_rdy;
  assign w_sel    = w_rdy[1];
  assign w_mis    = |w_addr[w_sel][OFS-1:0];
  assign w_cs     = w_acc & ~w_mis;
  assign w_we     = w_cs & ~w_crd[w_sel];

  assign bus.p0_cmd_ready = w_rdy[0];
  assign bus.p1_cmd_ready = w_rdy[1];
  assign bus.ram_cs       = w_cs;
  assign bus.ram_we       = w_we;
  assign bus.ram_addr     = w_addr[w_sel][ADDR_W-1:OFS];
  assign bus.ram_wem      = w_we ? w_wm[w_sel] : '0;
  assign bus.ram_din      = w_wd[w_sel];

  // Tag pipeline tracks each accepted command until its RAM data is available.
  logic [RAM_LAT:1] r_vld_pipe;
  tag_t             r_tag [RAM_LAT:1];
  tag_t             w_tag_in;

  assign w_tag_in = '{port: w_sel, read: w_crd[w_sel], err: w_mis};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      for (int k = 1; k <= RAM_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_vld_pipe[1] <= w_acc;
      r_tag[1]      <= w_tag_in;
      for (int k = 2; k <= RAM_LAT; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_tag[k]      <= r_tag[k-1];
      end
    end
  end

  rsp_t          r_fifo [RSP_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_fcnt;
  logic          w_push, w_pop, w_ne;
  tag_t          w_ptag;
  rsp_t          w_pent, w_head;

  assign w_push = r_vld_pipe[RAM_LAT];
  assign w_ptag = r_tag[RAM_LAT];
  assign w_pent = '{port: w_ptag.port, err: w_ptag.err,
                    data: (w_ptag.read & ~w_ptag.err) ? bus.ram_dout : '0};
  assign w_ne   = r_fcnt != '0;
  assign w_head = r_fifo[r_rp];
  assign w_rv   = {w_ne & w_head.port, w_ne & ~w_head.port};
  assign w_pop  = |(w_rv & w_rr_in);

  assign bus.p0_rsp_valid = w_rv[0];
  assign bus.p1_rsp_valid = w_rv[1];
  assign bus.p0_rsp_err   = w_rv[0] & w_head.err;
  assign bus.p1_rsp_err   = w_rv[1] & w_head.err;
  assign bus.p0_rsp_rdata = w_rv[0] ? w_head.data : '0;
  assign bus.p1_rsp_rdata = w_rv[1] ? w_head.data : '0;
  assign bus.busy         = r_outst != '0;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Outstanding counts pipeline plus FIFO occupancy, so a push never finds the FIFO full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_fcnt  <= '0;
      r_outst <= '0;
      r_rr    <= 1'b0;
    end else begin
      if (w_push) r_wp <= nxt(r_wp);
      if (w_pop)  r_rp <= nxt(r_rp);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CW'(1);
        2'b01:   r_fcnt <= r_fcnt - CW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      case ({w_acc, w_pop})
        2'b10:   r_outst <= r_outst + CW'(1);
        2'b01:   r_outst <= r_outst - CW'(1);
        default: r_outst <= r_outst;
      endcase
      if (w_acc && (w_sel == r_rr)) r_rr <= ~r_rr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= w_pent;
  end
endmodule

// File: tb/tb_dtcm_arb_ctrl.sv
// Directed bench: u0 (RAM_LAT=1, depth 2) runs a cycle table plus backpressure and
// reset sequences; u1 (RAM_LAT=2, depth 3) covers the two-cycle RAM latency.
module tb_dtcm_arb_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dtcm_arb_if #(.DW(32), .ADDR_W(16)) b0();
  dtcm_arb_if #(.DW(32), .ADDR_W(16)) b1();

  dtcm_arb_ctrl #(.DW(32), .ADDR_W(16), .RAM_LAT(1), .RSP_DEPTH(2)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  dtcm_arb_ctrl #(.DW(32), .ADDR_W(16), .RAM_LAT(2), .RSP_DEPTH(3)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));

  // RAM models: contents re-initialised to A000_0000|index while rst is high.
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] d0, d1a, d1b;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem0[i] <= 32'hA000_0000 | i;
    end else if (b0.ram_cs) begin
      if (b0.ram_we) begin
        for (int i = 0; i < 4; i++)
          if (b0.ram_wem[i]) mem0[b0.ram_addr[7:0]][8*i +: 8] <= b0.ram_din[8*i +: 8];
      end else d0 <= mem0[b0.ram_addr[7:0]];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 32'hA000_0000 | i;
    end else if (b1.ram_cs && !b1.ram_we) d1a <= mem1[b1.ram_addr[7:0]];
    d1b <= d1a;
  end

  assign b0.ram_dout = d0;
  assign b1.ram_dout = d1b;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic v0, r0; logic [15:0] a0;
    logic v1, r1; logic [15:0] a1;
    logic [31:0] wd; logic [3:0] wm;
    logic e_rdy0, e_rdy1, e_cs, e_we; logic [13:0] e_ra; logic [3:0] e_wem;
    logic e_rv0, e_rv1, e_err; logic [31:0] e_rd; logic e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic v0, r0, input logic [15:0] a0, input logic v1, r1, input logic [15:0] a1,
    input logic [31:0] wd, input logic [3:0] wm,
    input logic rdy0, rdy1, cs, we, input logic [13:0] ra, input logic [3:0] wem,
    input logic rv0, rv1, err, input logic [31:0] rd, input logic bsy);
    vec_t v;
    v.v0 = v0; v.r0 = r0; v.a0 = a0; v.v1 = v1; v.r1 = r1; v.a1 = a1; v.wd = wd; v.wm = wm;
    v.e_rdy0 = rdy0; v.e_rdy1 = rdy1; v.e_cs = cs; v.e_we = we; v.e_ra = ra; v.e_wem = wem;
    v.e_rv0 = rv0; v.e_rv1 = rv1; v.e_err = err; v.e_rd = rd; v.e_busy = bsy;
    return v;
  endfunction

  localparam int NV = 21;
  vec_t tbl [NV];

  task automatic idle0();
    b0.p0_cmd_valid = 0; b0.p0_cmd_read = 0; b0.p0_cmd_addr = 0; b0.p0_cmd_wmask = 0; b0.p0_cmd_wdata = 0;
    b0.p1_cmd_valid = 0; b0.p1_cmd_read = 0; b0.p1_cmd_addr = 0; b0.p1_cmd_wmask = 0; b0.p1_cmd_wdata = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Arbitration, writes, masked write, misaligned error; rsp_ready held high.
    tbl[0]  = mk(1,1,16'h0,  1,1,16'h8,  0,0,  1,0,1,0,0,0,  0,0,0,0, 0);
    tbl[1]  = mk(1,1,16'h0,  1,1,16'h8,  0,0,  0,1,1,0,2,0,  0,0,0,0, 1);
    tbl[2]  = mk(1,1,16'h0,  1,1,16'h8,  0,0,  0,0,0,0,0,0,  1,0,0,32'hA000_0000, 1);
    tbl[3]  = mk(1,1,16'h0,  1,1,16'h8,  0,0,  1,0,1,0,0,0,  0,1,0,32'hA000_0002, 1);
    tbl[4]  = mk(1,1,16'h0,  1,1,16'h8,  0,0,  0,1,1,0,2,0,  0,0,0,0, 1);
    tbl[5]  = mk(1,1,16'h0,  1,1,16'h8,  0,0,  0,0,0,0,0,0,  1,0,0,32'hA000_0000, 1);
    tbl[6]  = mk(1,1,16'h0,  1,1,16'h8,  0,0,  1,0,1,0,0,0,  0,1,0,32'hA000_0002, 1);
    tbl[7]  = mk(0,0,16'h0,  0,0,16'h0,  0,0,  0,0,0,0,0,0,  0,0,0,0, 1);
    tbl[8]  = mk(0,0,16'h0,  0,0,16'h0,  0,0,  0,0,0,0,0,0,  1,0,0,32'hA000_0000, 1);
    tbl[9]  = mk(1,0,16'h10, 0,0,16'h0,  32'hDEAD_BEEF,4'hF,  1,0,1,1,4,4'hF,  0,0,0,0, 0);
    tbl[10] = mk(1,1,16'h10, 0,0,16'h0,  32'hDEAD_BEEF,4'hF,  1,0,1,0,4,0,  0,0,0,0, 1);
    tbl[11] = mk(0,0,16'h0,  0,0,16'h0,  0,0,  0,0,0,0,0,0,  1,0,0,0, 1);
    tbl[12] = mk(0,0,16'h0,  0,0,16'h0,  0,0,  0,0,0,0,0,0,  1,0,0,32'hDEAD_BEEF, 1);
    tbl[13] = mk(0,0,16'h0,  1,0,16'h14, 32'h1234_5678,4'h3,  0,1,1,1,5,4'h3,  0,0,0,0, 0);
    tbl[14] = mk(0,0,16'h0,  1,1,16'h14, 0,0,  0,1,1,0,5,0,  0,0,0,0, 1);
    tbl[15] = mk(0,0,16'h0,  0,0,16'h0,  0,0,  0,0,0,0,0,0,  0,1,0,0, 1);
    tbl[16] = mk(0,0,16'h0,  0,0,16'h0,  0,0,  0,0,0,0,0,0,  0,1,0,32'hA000_5678, 1);
    tbl[17] = mk(0,0,16'h0,  1,1,16'h6,  0,0,  0,1,0,0,0,0,  0,0,0,0, 0);
    tbl[18] = mk(0,0,16'h0,  0,0,16'h0,  0,0,  0,0,0,0,0,0,  0,0,0,0, 1);
    tbl[19] = mk(0,0,16'h0,  0,0,16'h0,  0,0,  0,0,0,0,0,0,  0,1,1,0, 1);
    tbl[20] = mk(0,0,16'h0,  0,0,16'h0,  0,0,  0,0,0,0,0,0,  0,0,0,0, 0);

    rst = 1'b1;
    idle0();
    b0.p0_rsp_ready = 1; b0.p1_rsp_ready = 1;
    b1.p0_cmd_valid = 0; b1.p0_cmd_read = 1; b1.p0_cmd_addr = 0; b1.p0_cmd_wmask = 0; b1.p0_cmd_wdata = 0;
    b1.p1_cmd_valid = 0; b1.p1_cmd_read = 0; b1.p1_cmd_addr = 0; b1.p1_cmd_wmask = 0; b1.p1_cmd_wdata = 0;
    b1.p0_rsp_ready = 1; b1.p1_rsp_ready = 1;
    b0.p0_cmd_valid = 1; b0.p0_cmd_read = 1;

    // Reset state, with a request pending to show ready stays gated.
    repeat (3) @(negedge clk);
    #1;
    chk("rst p0_cmd_ready", b0.p0_cmd_ready, 0);
    chk("rst ram_cs", b0.ram_cs, 0);
    chk("rst ram_we", b0.ram_we, 0);
    chk("rst busy", b0.busy, 0);
    chk("rst p0_rsp_valid", b0.p0_rsp_valid, 0);
    chk("rst p1_rsp_valid", b0.p1_rsp_valid, 0);
    chk("rst p0_rsp_rdata", b0.p0_rsp_rdata, 0);
    chk("rst p1_rsp_err", b0.p1_rsp_err, 0);
    chk("rst u1 busy", b1.busy, 0);
    idle0();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      b0.p0_cmd_valid = tbl[i].v0; b0.p0_cmd_read = tbl[i].r0; b0.p0_cmd_addr = tbl[i].a0;
      b0.p0_cmd_wdata = tbl[i].wd; b0.p0_cmd_wmask = tbl[i].wm;
      b0.p1_cmd_valid = tbl[i].v1; b0.p1_cmd_read = tbl[i].r1; b0.p1_cmd_addr = tbl[i].a1;
      b0.p1_cmd_wdata = tbl[i].wd; b0.p1_cmd_wmask = tbl[i].wm;
      #1;
      chk($sformatf("row%0d p0_cmd_ready", i), b0.p0_cmd_ready, tbl[i].e_rdy0);
      chk($sformatf("row%0d p1_cmd_ready", i), b0.p1_cmd_ready, tbl[i].e_rdy1);
      chk($sformatf("row%0d ram_cs", i), b0.ram_cs, tbl[i].e_cs);
      chk($sformatf("row%0d ram_we", i), b0.ram_we, tbl[i].e_we);
      chk($sformatf("row%0d ram_wem", i), b0.ram_wem, tbl[i].e_wem);
      if (tbl[i].e_cs) chk($sformatf("row%0d ram_addr", i), b0.ram_addr, tbl[i].e_ra);
      chk($sformatf("row%0d p0_rsp_valid", i), b0.p0_rsp_valid, tbl[i].e_rv0);
      chk($sformatf("row%0d p1_rsp_valid", i), b0.p1_rsp_valid, tbl[i].e_rv1);
      if (tbl[i].e_rv0) begin
        chk($sformatf("row%0d p0_rsp_err", i), b0.p0_rsp_err, tbl[i].e_err);
        chk($sformatf("row%0d p0_rsp_rdata", i), b0.p0_rsp_rdata, tbl[i].e_rd);
      end
      if (tbl[i].e_rv1) begin
        chk($sformatf("row%0d p1_rsp_err", i), b0.p1_rsp_err, tbl[i].e_err);
        chk($sformatf("row%0d p1_rsp_rdata", i), b0.p1_rsp_rdata, tbl[i].e_rd);
      end
      chk($sformatf("row%0d busy", i), b0.busy, tbl[i].e_busy);
    end

    // Credit exhaustion with a stalled response, then release.
    @(negedge clk);
    idle0();
    b0.p0_rsp_ready = 0; b0.p0_cmd_valid = 1; b0.p0_cmd_read = 1; b0.p0_cmd_addr = 16'h0;
    #1 chk("bp accept1", b0.p0_cmd_ready, 1);
    @(negedge clk); #1 chk("bp accept2", b0.p0_cmd_ready, 1);
    @(negedge clk); #1;
    chk("bp full ready", b0.p0_cmd_ready, 0);
    chk("bp head valid", b0.p0_rsp_valid, 1);
    chk("bp head rdata", b0.p0_rsp_rdata, 32'hA000_0000);
    @(negedge clk);
    b0.p0_rsp_ready = 1;
    #1;
    chk("bp pop cycle ready", b0.p0_cmd_ready, 0);
    chk("bp held rdata", b0.p0_rsp_rdata, 32'hA000_0000);
    @(negedge clk); #1;
    chk("bp accept3", b0.p0_cmd_ready, 1);
    chk("bp second rsp", b0.p0_rsp_valid, 1);
    @(negedge clk);
    b0.p0_cmd_valid = 0;
    begin
      int n = 0;
      while (b0.busy && n < 10) begin @(negedge clk); n++; end
      #1 chk("bp drain busy", b0.busy, 0);
    end

    // Two-cycle RAM latency: back-to-back reads on u1.
    @(negedge clk);
    b1.p0_cmd_valid = 1; b1.p0_cmd_addr = 16'h0;
    #1 chk("lat2 accept0", b1.p0_cmd_ready, 1);
    @(negedge clk);
    b1.p0_cmd_addr = 16'h4;
    #1 chk("lat2 accept1", b1.p0_cmd_ready, 1);
    chk("lat2 N+1 valid", b1.p0_rsp_valid, 0);
    @(negedge clk);
    b1.p0_cmd_valid = 0;
    #1 chk("lat2 N+2 valid", b1.p0_rsp_valid, 0);
    @(negedge clk); #1;
    chk("lat2 N+3 valid", b1.p0_rsp_valid, 1);
    chk("lat2 N+3 rdata", b1.p0_rsp_rdata, 32'hA000_0000);
    @(negedge clk); #1;
    chk("lat2 N+4 valid", b1.p0_rsp_valid, 1);
    chk("lat2 N+4 rdata", b1.p0_rsp_rdata, 32'hA000_0001);
    @(negedge clk); #1;
    chk("lat2 done valid", b1.p0_rsp_valid, 0);
    chk("lat2 done busy", b1.busy, 0);

    // Asynchronous reset with two commands outstanding.
    @(negedge clk);
    b0.p0_rsp_ready = 0; b0.p0_cmd_valid = 1; b0.p0_cmd_addr = 16'h0;
    @(negedge clk);
    @(negedge clk);
    b0.p0_cmd_valid = 0;
    #1;
    chk("arst pre busy", b0.busy, 1);
    chk("arst pre valid", b0.p0_rsp_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst valid drop", b0.p0_rsp_valid, 0);
    chk("arst busy drop", b0.busy, 0);
    chk("arst rdata zero", b0.p0_rsp_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    b0.p0_rsp_ready = 1; b0.p0_cmd_valid = 1; b0.p0_cmd_addr = 16'h4;
    #1 chk("post rst first accept", b0.p0_cmd_ready, 1);
    @(negedge clk);
    b0.p0_cmd_valid = 0;
    #1;
    chk("post rst no stale p0", b0.p0_rsp_valid, 0);
    chk("post rst no stale p1", b0.p1_rsp_valid, 0);
    @(negedge clk); #1;
    chk("post rst rsp valid", b0.p0_rsp_valid, 1);
    chk("post rst rsp rdata", b0.p0_rsp_rdata, 32'hA000_0001);
    @(negedge clk); #1;
    chk("post rst single rsp", b0.p0_rsp_valid, 0);
    chk("post rst busy", b0.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dtcm_arb_ctrl.md
DTCM_ARB_CTRL -- requirements
Module: dtcm_arb_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DW, default 32, meaning RAM/data width in bits (32 or 64).
REQ-003 Parameter ADDR_W, default 16, meaning byte-address width of each command port.
REQ-004 Parameter RAM_LAT, default 1, meaning RAM read latency in cycles (1 or 2).
REQ-005 Parameter RSP_DEPTH, default 2, meaning max outstanding commands and response-FIFO depth (2..8).
REQ-006 Derived: MW=DW/8, OFS=log2(MW), RAM_AW=ADDR_W-OFS.
REQ-007 Ports, per line: name, direction, width, meaning:
  clk  in  1  clock
  rst  in  1  asynchronous active-high reset
  pX_cmd_valid  in  1  command request, X in {0 (LSU), 1 (external/debug)}
  pX_cmd_ready  out  1  command accepted this cycle when high with valid
  pX_cmd_read  in  1  1=read, 0=write
  pX_cmd_addr  in  ADDR_W  byte address
  pX_cmd_wmask  in  MW  byte write enables
  pX_cmd_wdata  in  DW  write data
  pX_rsp_valid  out  1  response available
  pX_rsp_ready  in  1  response consumed when high with valid
  pX_rsp_rdata  out  DW  read data; 0 for writes and errors
  pX_rsp_err  out  1  misaligned-address error flag
  ram_cs  out  1  RAM access strobe
  ram_we  out  1  RAM write enable
  ram_addr  out  RAM_AW  RAM word address
  ram_wem  out  MW  RAM byte write mask
  ram_din  out  DW  RAM write data
  ram_dout  in  DW  RAM read data, valid RAM_LAT cycles after ram_cs
  busy  out  1  any command outstanding

Function
REQ-008 Accept: at most one command per cycle; credit_ok = (outstanding < RSP_DEPTH); pX_cmd_ready = grantX & credit_ok, combinational.
REQ-009 Arbiter: only one valid port -> it is granted; both valid -> port named by 1-bit RR pointer granted; pointer flips to the other port only on an accepted command from the pointed port; reset value 0 (p0 priority).
REQ-010 Aligned accept (addr[OFS-1:0]==0): ram_cs=1, ram_we=~read, ram_addr=addr[ADDR_W-1:OFS], ram_wem=wmask on write / 0 on read, ram_din=wdata, same cycle.
REQ-011 Misaligned accept: ram_cs=0, no RAM access; response carries err=1, rdata=0.
REQ-012 No accept: ram_cs=0, ram_we=0, ram_wem=0.
REQ-013 Every accepted command (read, write, error) SHALL produce exactly one response, to the issuing port, in global acceptance order.
REQ-014 Tag pipeline: RAM_LAT stages carry {port, read, err}; at stage exit entry {port, err, read&~err ? ram_dout : 0} is pushed into a single RSP_DEPTH-entry response FIFO.
REQ-015 Latency: command accepted in cycle N -> pX_rsp_valid high in cycle N+RAM_LAT+1 when FIFO was empty.
REQ-016 pX_rsp_valid = FIFO non-empty & head.port==X; head pops on pX_rsp_valid & pX_rsp_ready; a stalled head blocks the other port's responses (head-of-line, by design).
REQ-017 Response outputs SHALL hold stable while valid & ~ready.
REQ-018 Outstanding counter (0..RSP_DEPTH): +1 on accept, -1 on pop, unchanged on simultaneous accept and pop; FIFO SHALL never overflow or underflow.
REQ-019 At outstanding==RSP_DEPTH, both cmd_ready low; a pop in the same cycle does not raise cmd_ready until the next cycle.
REQ-020 FIFO pointers wrap modulo RSP_DEPTH; non-power-of-two depths supported.
REQ-021 busy = (outstanding != 0).

Reset
REQ-022 While rst high: outstanding=0, FIFO empty, tag pipeline invalid, RR pointer=0; all pX_cmd_ready, pX_rsp_valid, pX_rsp_err, ram_cs, ram_we, busy =0; rdata outputs 0.
REQ-023 Reset mid-operation SHALL discard all in-flight commands and queued responses without emitting responses after release.
REQ-024 First accept permitted in the first clock edge after rst deasserts.

Verification
REQ-025 RAM_LAT=1: p0 write addr 0x10, wdata 0xDEADBEEF, wmask 0xF, then read 0x10 -> ram_addr=0x4 both; write rsp err=0 rdata=0; read rsp rdata 0xDEADBEEF at N+2.
REQ-026 Both ports valid continuously, rsp_ready=1 -> grants alternate p0,p1,p0,p1 starting p0; each port gets responses in its issue order.
REQ-027 RSP_DEPTH=2, p0_rsp_ready=0, three reads on p0 -> two accepted, third cmd_ready=0; raise rsp_ready -> third accepted the cycle after first pop.
REQ-028 p1 read addr 0x6 (DW=32) -> ram_cs=0, p1_rsp_err=1, rdata=0, outstanding returns to 0.
REQ-029 RAM_LAT=2, back-to-back reads 0x0,0x4 -> responses at N+3, N+4 with correct data.
REQ-030 Assert rst with 2 outstanding -> all valids drop asynchronously, busy=0; no stale response after release.
